// File: rtl/pid_ppm_encoder.sv
// -----------------------------------------------------------------------------
// pid_ppm_encoder
//
// Turns the four clamped PID outputs (roll, pitch, throttle, yaw) into a
// standard 4-channel PPM stream for the RC transmitter trainer port.
// Incoming values land in a staging set; the whole set is copied into a
// shadow set once per frame, so a frame never mixes old and new channels.
//
// Ports
//   clk                 in   1   system clock
//   reset               in   1   synchronous, active-high
//   sink_data_valid     in   1   strobe: write sink_pid into sink_channel
//   sink_channel        in   2   channel index 0..3
//   sink_pid            in   15  signed PID value, nominal [0,12240]
//   ppm_out             out  1   PPM stream
//   source_frame_start  out  1   one-cycle pulse marking the start of a frame
//   source_channel      out  3   channel being emitted, 4 = closing sep / sync
// -----------------------------------------------------------------------------
module pid_ppm_encoder #(
    parameter int unsigned FRAME_TICKS = 1000000,
    parameter int unsigned MIN_TICKS   = 50000,
    parameter int unsigned SCALE_MUL   = 16731,
    parameter int unsigned SCALE_SHIFT = 12,
    parameter int unsigned SEP_TICKS   = 15000,
    parameter int unsigned NEUTRAL     = 6120,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sink_data_valid,
    input  logic [1:0]  sink_channel,
    input  logic [14:0] sink_pid,
    output logic        ppm_out,
    output logic        source_frame_start,
    output logic [2:0]  source_channel
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SEP,
        S_CH,
        S_SYNC
    } state_t;

    localparam logic [14:0] PID_MAX    = 15'd12240;
    localparam logic [14:0] NEUTRAL_V  = 15'(NEUTRAL);
    localparam logic [31:0] FRAME_LAST = 32'(FRAME_TICKS - 1);
    localparam logic [31:0] SEP_LAST   = 32'(SEP_TICKS - 1);
    localparam logic [31:0] SEP_W      = 32'(SEP_TICKS);
    localparam logic [31:0] MIN_W      = 32'(MIN_TICKS);
    localparam logic [31:0] MUL_W      = 32'(SCALE_MUL);

    logic [14:0] staging [4];
    logic [14:0] shadow  [4];
    state_t      state;
    logic [2:0]  ch;
    logic [31:0] seg_cnt;
    logic [31:0] frame_cnt;
    logic [31:0] width_cur;
    logic [14:0] pid_clamped;
    logic [31:0] product;

    // Clamp the incoming value to the legal stick range and form the span
    // product for whichever channel is currently selected. Only ch[1:0] is
    // used for the lookup; when ch is 4 the result is simply not consumed.
    always_comb begin
        pid_clamped = sink_pid;
        if (sink_pid[14]) begin
            pid_clamped = '0;
        end else if (sink_pid > PID_MAX) begin
            pid_clamped = PID_MAX;
        end
        product = {17'd0, shadow[ch[1:0]]} * MUL_W;
    end

    // Staging set: written by the PID side at any time. A write in the same
    // cycle as the frame load lands here only and shows up one frame later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                staging[i] <= NEUTRAL_V;
            end
        end else if (sink_data_valid) begin
            staging[sink_channel] <= pid_clamped;
        end
    end

    // Width of the current channel, registered from the shadow set. It
    // settles one cycle into each separator, long before the channel body
    // that consumes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            width_cur <= '0;
        end else begin
            width_cur <= MIN_W + (product >> SCALE_SHIFT);
        end
    end

    // Frame sequencer. The frame counter free-runs and wraps, and the only
    // way back to S_LOAD is through its last count, so the frame period is
    // exact regardless of channel content. Separator leading edges are
    // spaced by the full channel width because the body lasts width-SEP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_LOAD;
            ch                 <= '0;
            seg_cnt            <= '0;
            frame_cnt          <= '0;
            ppm_out            <= IDLE_LEVEL;
            source_frame_start <= 1'b0;
            source_channel     <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= NEUTRAL_V;
            end
        end else begin
            source_frame_start <= 1'b0;
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 32'd1;
            end

            case (state)
                S_LOAD: begin
                    for (int i = 0; i < 4; i++) begin
                        shadow[i] <= staging[i];
                    end
                    ch                 <= '0;
                    seg_cnt            <= '0;
                    source_frame_start <= 1'b1;
                    source_channel     <= '0;
                    ppm_out            <= ~IDLE_LEVEL;
                    state              <= S_SEP;
                end

                S_SEP: begin
                    if (seg_cnt == SEP_LAST) begin
                        seg_cnt <= '0;
                        ppm_out <= IDLE_LEVEL;
                        if (ch < 3'd4) begin
                            state <= S_CH;
                        end else begin
                            state <= S_SYNC;
                        end
                    end else begin
                        seg_cnt <= seg_cnt + 32'd1;
                    end
                end

                S_CH: begin
                    if (seg_cnt == width_cur - SEP_W - 32'd1) begin
                        seg_cnt        <= '0;
                        ch             <= ch + 3'd1;
                        source_channel <= ch + 3'd1;
                        ppm_out        <= ~IDLE_LEVEL;
                        state          <= S_SEP;
                    end else begin
                        seg_cnt <= seg_cnt + 32'd1;
                    end
                end

                S_SYNC: begin
                    if (frame_cnt == FRAME_LAST) begin
                        state <= S_LOAD;
                    end
                end

                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_ppm_encoder.sv
// -----------------------------------------------------------------------------
// tb_pid_ppm_encoder
//
// Self-checking bench for pid_ppm_encoder, run with shortened timing so a
// frame is 2000 cycles. Whole frames are captured sample by sample and the
// separator edges are compared against a reference model that tracks the
// staging/shadow value sets and turns each value into a width arithmetically.
// -----------------------------------------------------------------------------
module tb_pid_ppm_encoder;

    localparam int FRAME   = 2000;
    localparam int MIN     = 100;
    localparam int MUL     = 34;
    localparam int SHIFT   = 12;
    localparam int SEP     = 30;
    localparam int NEUTRAL = 6120;
    localparam int PID_MAX = 12240;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sink_data_valid = 1'b0;
    logic [1:0]  sink_channel = '0;
    logic [14:0] sink_pid = '0;
    logic        ppm_out;
    logic        source_frame_start;
    logic [2:0]  source_channel;

    pid_ppm_encoder #(
        .FRAME_TICKS (FRAME),
        .MIN_TICKS   (MIN),
        .SCALE_MUL   (MUL),
        .SCALE_SHIFT (SHIFT),
        .SEP_TICKS   (SEP),
        .NEUTRAL     (NEUTRAL),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sink_data_valid    (sink_data_valid),
        .sink_channel       (sink_channel),
        .sink_pid           (sink_pid),
        .ppm_out            (ppm_out),
        .source_frame_start (source_frame_start),
        .source_channel     (source_channel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        int raw;
    } wr_t;

    wr_t  sched[$];
    int   checks = 0;
    int   failures = 0;
    int   model_staging [4];
    int   model_shadow  [4];
    int   cap_used      [4];
    int   exp_edge      [5];
    int   cap_timeout;
    logic       cap_ppm [FRAME+1];
    logic [2:0] cap_ch  [FRAME+1];
    logic       cap_fs  [FRAME+1];
    int   edge_pos[$];
    int   low_len[$];
    int   gap_len;
    int   fs_extra;

    // Raw 15-bit two's complement pattern -> value held in the channel.
    function automatic int pid_value(input int raw);
        int v;
        v = (raw >= 16384) ? raw - 32768 : raw;
        if (v < 0) return 0;
        if (v > PID_MAX) return PID_MAX;
        return v;
    endfunction

    function automatic int width_of(input int v);
        return MIN + (v * MUL) / (1 << SHIFT);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            model_staging[k] = NEUTRAL;
            model_shadow[k]  = NEUTRAL;
        end
    endfunction

    function automatic void compute_expected();
        exp_edge[0] = 0;
        for (int k = 0; k < 4; k++) begin
            exp_edge[k+1] = exp_edge[k] + width_of(cap_used[k]);
        end
    endfunction

    // Extract separator leading edges, their low lengths, the high time
    // after the closing separator and any stray frame-start pulses.
    function automatic void measure();
        int run;
        edge_pos.delete();
        low_len.delete();
        gap_len  = 0;
        fs_extra = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (cap_ppm[i] === 1'b0 && (i == 0 || cap_ppm[i-1] === 1'b1)) begin
                run = 0;
                for (int j = i; j < FRAME && cap_ppm[j] === 1'b0; j++) run++;
                edge_pos.push_back(i);
                low_len.push_back(run);
            end
            if (i > 0 && cap_fs[i] === 1'b1) fs_extra++;
        end
        if (edge_pos.size() > 0) begin
            for (int i = edge_pos[edge_pos.size()-1] + low_len[low_len.size()-1]; i < FRAME; i++) begin
                if (cap_ppm[i] === 1'b1) gap_len++;
            end
        end
    endfunction

    // Record one whole frame starting at a frame-start pulse, applying the
    // scheduled writes on the way. Indices are cycles from the pulse; index
    // FRAME-1 is the load cycle of the following frame.
    task automatic capture_frame();
        int n;
        int next_shadow [4];
        n = 0;
        cap_timeout = 0;
        edge_pos.delete();
        low_len.delete();
        while (source_frame_start !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (source_frame_start !== 1'b1) begin
            cap_timeout = 1;
            sched.delete();
            return;
        end
        cap_used    = model_shadow;
        next_shadow = model_staging;
        for (int i = 0; i <= FRAME; i++) begin
            cap_ppm[i] = ppm_out;
            cap_ch[i]  = source_channel;
            cap_fs[i]  = source_frame_start;
            if (i < FRAME) begin
                sink_data_valid = 1'b0;
                if (i == FRAME - 1) next_shadow = model_staging;
                foreach (sched[j]) begin
                    if (sched[j].cyc == i) begin
                        sink_data_valid = 1'b1;
                        sink_channel    = 2'(sched[j].ch);
                        sink_pid        = 15'(sched[j].raw);
                        model_staging[sched[j].ch] = pid_value(sched[j].raw);
                    end
                end
                @(negedge clk);
            end
        end
        sink_data_valid = 1'b0;
        sched.delete();
        model_shadow = next_shadow;
        measure();
    endtask

    task automatic add_write(input int cyc, input int ch, input int raw);
        wr_t w;
        w.cyc = cyc;
        w.ch  = ch;
        w.raw = raw;
        sched.push_back(w);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sink_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ppm_out !== 1'b1) begin
                failures++; $display("[TB] FAIL reset_ppm: got %0b expected 1", ppm_out);
            end
            checks++;
            if (source_frame_start !== 1'b0) begin
                failures++; $display("[TB] FAIL reset_frame_start: got %0b expected 0", source_frame_start);
            end
            checks++;
            if (source_channel !== 3'd0) begin
                failures++; $display("[TB] FAIL reset_channel: got %0d expected 0", source_channel);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (source_frame_start !== 1'b1 || ppm_out !== 1'b0) begin
            failures++; $display("[TB] FAIL first_frame: got fs=%0b ppm=%0b expected fs=1 ppm=0", source_frame_start, ppm_out);
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            compute_expected();
            checks++;
            if (edge_pos.size() != 5) begin
                failures++; $display("[TB] FAIL neutral_edge_count: got %0d expected 5", edge_pos.size());
            end else begin
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (edge_pos[k] != k * 150) begin
                        failures++; $display("[TB] FAIL neutral_edge%0d: got %0d expected %0d", k, edge_pos[k], k * 150);
                    end
                    checks++;
                    if (low_len[k] != SEP) begin
                        failures++; $display("[TB] FAIL neutral_sep%0d: got %0d expected %0d", k, low_len[k], SEP);
                    end
                    checks++;
                    if (cap_ch[edge_pos[k] + 1] !== 3'(k)) begin
                        failures++; $display("[TB] FAIL neutral_channel%0d: got %0d expected %0d", k, cap_ch[edge_pos[k] + 1], k);
                    end
                end
            end
            checks++;
            if (cap_fs[FRAME] !== 1'b1 || fs_extra != 0) begin
                failures++; $display("[TB] FAIL frame_period: got end_fs=%0b extra=%0d expected end_fs=1 extra=0", cap_fs[FRAME], fs_extra);
            end
            checks++;
            if (gap_len != FRAME - exp_edge[4] - SEP) begin
                failures++; $display("[TB] FAIL neutral_gap: got %0d expected %0d", gap_len, FRAME - exp_edge[4] - SEP);
            end
        end
    endtask

    task automatic test_channel_values();
        int lit_w [4] = '{100, 201, 150, 100};
        add_write(100, 0, 0);
        add_write(101, 1, 12240);
        add_write(102, 2, 6120);
        add_write(103, 3, 32763);
        capture_frame();
        compute_expected();
        checks++;
        if (edge_pos.size() != 5 || edge_pos[4] != exp_edge[4]) begin
            failures++; $display("[TB] FAIL values_frame_in_flight: got %0d edges expected 5 ending at %0d", edge_pos.size(), exp_edge[4]);
        end
        capture_frame();
        checks++;
        if (edge_pos.size() != 5) begin
            failures++; $display("[TB] FAIL values_edge_count: got %0d expected 5", edge_pos.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (edge_pos[k+1] - edge_pos[k] != lit_w[k]) begin
                    failures++; $display("[TB] FAIL values_width%0d: got %0d expected %0d", k, edge_pos[k+1] - edge_pos[k], lit_w[k]);
                end
            end
        end
    endtask

    task automatic test_clamp_high();
        add_write(200, 1, 16383);
        capture_frame();
        capture_frame();
        compute_expected();
        checks++;
        if (edge_pos.size() != 5) begin
            failures++; $display("[TB] FAIL clamp_edge_count: got %0d expected 5", edge_pos.size());
        end else begin
            checks++;
            if (edge_pos[2] - edge_pos[1] != 201) begin
                failures++; $display("[TB] FAIL clamp_width1: got %0d expected 201", edge_pos[2] - edge_pos[1]);
            end
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (edge_pos[k] != exp_edge[k]) begin
                    failures++; $display("[TB] FAIL clamp_edge%0d: got %0d expected %0d", k, edge_pos[k], exp_edge[k]);
                end
            end
        end
        checks++;
        if (gap_len != FRAME - exp_edge[4] - SEP) begin
            failures++; $display("[TB] FAIL clamp_gap: got %0d expected %0d", gap_len, FRAME - exp_edge[4] - SEP);
        end
    endtask

    task automatic test_load_collision();
        int lit_ch2 [3] = '{150, 100, 201};
        add_write(700, 2, 0);
        add_write(FRAME - 1, 2, 12240);
        for (int f = 0; f < 3; f++) begin
            capture_frame();
            compute_expected();
            checks++;
            if (edge_pos.size() != 5) begin
                failures++; $display("[TB] FAIL collision_edge_count%0d: got %0d expected 5", f, edge_pos.size());
            end else begin
                checks++;
                if (edge_pos[3] - edge_pos[2] != lit_ch2[f]) begin
                    failures++; $display("[TB] FAIL collision_width_frame%0d: got %0d expected %0d", f, edge_pos[3] - edge_pos[2], lit_ch2[f]);
                end
                checks++;
                if (edge_pos[4] != exp_edge[4]) begin
                    failures++; $display("[TB] FAIL collision_close_frame%0d: got %0d expected %0d", f, edge_pos[4], exp_edge[4]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int raw [4];
        for (int k = 0; k < 4; k++) begin
            raw[k] = $urandom_range(0, 32767);
            add_write(40 + k, k, raw[k]);
        end
        capture_frame();
        capture_frame();
        checks++;
        if (edge_pos.size() != 5) begin
            failures++; $display("[TB] FAIL b2b_edge_count: got %0d expected 5", edge_pos.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (edge_pos[k+1] - edge_pos[k] != width_of(pid_value(raw[k]))) begin
                    failures++; $display("[TB] FAIL b2b_width%0d: got %0d expected %0d", k, edge_pos[k+1] - edge_pos[k], width_of(pid_value(raw[k])));
                end
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int it = 0; it < 5; it++) begin
            cyc = $urandom_range(0, 400);
            if (it < 4) begin
                for (int n = 0; n < 6 && cyc < FRAME; n++) begin
                    if ($urandom_range(0, 1) == 1) add_write(cyc, $urandom_range(0, 3), $urandom_range(0, 12240));
                    else add_write(cyc, $urandom_range(0, 3), $urandom_range(0, 32767));
                    cyc = ($urandom_range(0, 3) == 0) ? cyc + 1 : cyc + $urandom_range(1, 400);
                    if (n == 4 && it == 2) cyc = FRAME - 1;
                end
            end
            capture_frame();
            compute_expected();
            checks++;
            if (edge_pos.size() != 5) begin
                failures++; $display("[TB] FAIL random%0d_edge_count: got %0d expected 5", it, edge_pos.size());
            end else begin
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (edge_pos[k] != exp_edge[k] || low_len[k] != SEP) begin
                        failures++; $display("[TB] FAIL random%0d_edge%0d: got pos=%0d low=%0d expected pos=%0d low=%0d", it, k, edge_pos[k], low_len[k], exp_edge[k], SEP);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        for (int k = 0; k < 4; k++) add_write(10 + k, k, 0);
        capture_frame();
        n = 0;
        while (!(source_channel === 3'd2 && ppm_out === 1'b1) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(source_channel === 3'd2 && ppm_out === 1'b1)) begin
            failures++; $display("[TB] FAIL midreset_reach_ch2: got ch=%0d ppm=%0b expected ch=2 ppm=1", source_channel, ppm_out);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ppm_out !== 1'b1 || source_frame_start !== 1'b0 || source_channel !== 3'd0) begin
            failures++; $display("[TB] FAIL midreset_outputs: got ppm=%0b fs=%0b ch=%0d expected 1 0 0", ppm_out, source_frame_start, source_channel);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (source_frame_start !== 1'b1) begin
            failures++; $display("[TB] FAIL midreset_frame_start: got %0b expected 1", source_frame_start);
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            checks++;
            if (edge_pos.size() != 5) begin
                failures++; $display("[TB] FAIL midreset_edge_count%0d: got %0d expected 5", f, edge_pos.size());
            end else begin
                for (int k = 1; k < 5; k++) begin
                    checks++;
                    if (edge_pos[k] != k * 150) begin
                        failures++; $display("[TB] FAIL midreset_edge%0d: got %0d expected %0d", k, edge_pos[k], k * 150);
                    end
                end
            end
        end
    endtask

    // Overall time bound so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_channel_values();
        test_clamp_high();
        test_load_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
